cordic_phase_sequencer: RTL and testbench

- Upstream driver for the iterative sin/cos CORDIC core.
- Generates a phase ramp (start phase plus N steps), issues one CORDIC request per phase, and waits for that request's done pulse.
- Returns each cosine/sine result to a downstream consumer over a valid/ready stream, together with the phase that produced it.
- Used for tone/NCO generation and sweep testing.

---
 rtl/cordic_phase_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_cordic_phase_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_sequencer.sv
// Phase-ramp sequencer driving an iterative sin/cos CORDIC core.
// Issues one request per phase step and streams each result out with its phase.
module cordic_phase_sequencer #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned ANGLE_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned TIMEOUT     = 256
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cfg_load,
    input  logic [ANGLE_WIDTH-1:0] cfg_phase_init,
    input  logic [ANGLE_WIDTH-1:0] cfg_phase_step,
    input  logic [COUNT_WIDTH-1:0] cfg_count,
    input  logic                   run,
    input  logic                   abort,
    output logic                   cordic_start,
    output logic [ANGLE_WIDTH-1:0] cordic_angle,
    output logic [WIDTH-1:0]       cordic_x_start,
    output logic [WIDTH-1:0]       cordic_y_start,
    input  logic [WIDTH-1:0]       cordic_cosine,
    input  logic [WIDTH-1:0]       cordic_sine,
    input  logic                   cordic_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_cos,
    output logic [WIDTH-1:0]       out_sin,
    output logic [ANGLE_WIDTH-1:0] out_phase,
    output logic                   out_last,
    output logic                   busy,
    output logic                   error_timeout
);

    localparam int unsigned FRAC_BITS = ANGLE_WIDTH - 3;
    localparam int unsigned EXT_W     = ANGLE_WIDTH + 2;
    localparam int unsigned TO_W      = $clog2(TIMEOUT) + 1;

    localparam logic signed [EXT_W-1:0] PI =
        EXT_W'(longint'(3.141592653589793 * (2.0 ** FRAC_BITS)));
    localparam logic signed [EXT_W-1:0] TWO_PI = PI <<< 1;
    localparam logic [WIDTH-1:0] GAIN =
        WIDTH'($rtoi(0.6072529350088812 * (2.0 ** (WIDTH - 2))));

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StOutput, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [ANGLE_WIDTH-1:0] init_q, init_d, step_q, step_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d, remaining_q, remaining_d;
    logic [ANGLE_WIDTH-1:0] phase_q, phase_d, angle_q, angle_d;
    logic [TO_W-1:0]        tcnt_q, tcnt_d;
    logic [WIDTH-1:0]       cos_q, cos_d, sin_q, sin_d;
    logic [ANGLE_WIDTH-1:0] out_phase_q, out_phase_d;
    logic                   last_q, last_d, err_q, err_d;

    logic [ANGLE_WIDTH-1:0] eff_init;
    logic [COUNT_WIDTH-1:0] eff_count;
    logic signed [EXT_W-1:0] sum, wrapped;
    logic                   timed_out;

    // Next phase, wrapped back into [-PI, PI) with two guard bits of headroom.
    always_comb begin
        sum = $signed({{2{phase_q[ANGLE_WIDTH-1]}}, phase_q})
            + $signed({{2{step_q[ANGLE_WIDTH-1]}}, step_q});
        if (sum >= PI) begin
            wrapped = sum - TWO_PI;
        end else if (sum < -PI) begin
            wrapped = sum + TWO_PI;
        end else begin
            wrapped = sum;
        end
    end

    assign timed_out = (tcnt_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        step_d      = step_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        phase_d     = phase_q;
        angle_d     = angle_q;
        cos_d       = cos_q;
        sin_d       = sin_q;
        out_phase_d = out_phase_q;
        last_d      = last_q;
        err_d       = err_q;
        eff_init    = cfg_load ? cfg_phase_init : init_q;
        eff_count   = cfg_load ? cfg_count : count_q;
        // Counts from the ISSUE cycle of the current request.
        tcnt_d      = (state_q == StIdle || state_q == StOutput) ? '0 : tcnt_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (cfg_load) begin
                    init_d  = cfg_phase_init;
                    step_d  = cfg_phase_step;
                    count_d = cfg_count;
                end
                if (run && !abort && eff_count != '0) begin
                    phase_d     = eff_init;
                    remaining_d = eff_count;
                    err_d       = 1'b0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                state_d = abort ? StDrain : StWait;
            end
            StWait: begin
                if (abort) begin
                    // A done arriving with the abort already retires the request.
                    state_d = cordic_done ? StIdle : StDrain;
                end else if (cordic_done) begin
                    cos_d       = cordic_cosine;
                    sin_d       = cordic_sine;
                    out_phase_d = phase_q;
                    last_d      = (remaining_q == COUNT_WIDTH'(1));
                    state_d     = StOutput;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StOutput: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (out_ready) begin
                    remaining_d = remaining_q - 1'b1;
                    phase_d     = wrapped[ANGLE_WIDTH-1:0];
                    state_d     = (remaining_q == COUNT_WIDTH'(1)) ? StIdle : StIssue;
                end
            end
            StDrain: begin
                if (cordic_done) begin
                    state_d = StIdle;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIssue) begin
            angle_d = phase_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            init_q      <= '0;
            step_q      <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            phase_q     <= '0;
            angle_q     <= '0;
            tcnt_q      <= '0;
            cos_q       <= '0;
            sin_q       <= '0;
            out_phase_q <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            step_q      <= step_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            phase_q     <= phase_d;
            angle_q     <= angle_d;
            tcnt_q      <= tcnt_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            out_phase_q <= out_phase_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

    assign cordic_start   = (state_q == StIssue);
    assign cordic_angle   = angle_q;
    assign cordic_x_start = GAIN;
    assign cordic_y_start = '0;
    assign out_valid      = (state_q == StOutput);
    assign out_cos        = cos_q;
    assign out_sin        = sin_q;
    assign out_phase      = out_phase_q;
    assign out_last       = last_q;
    assign busy           = (state_q != StIdle);
    assign error_timeout  = err_q;

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Self-checking bench for cordic_phase_sequencer: stub CORDIC core with fixed
// latency, table-driven sweeps checked through an expected-sample scoreboard.
module tb_cordic_phase_sequencer;

    localparam int W   = 16;
    localparam int AW  = 32;
    localparam int CW  = 16;
    localparam int TO  = 256;
    localparam int LAT = 20;

    logic          clock = 1'b0;
    logic          reset;
    logic          cfg_load, run, abort, out_ready;
    logic [AW-1:0] cfg_phase_init, cfg_phase_step;
    logic [CW-1:0] cfg_count;
    logic          cordic_start, cordic_done;
    logic [AW-1:0] cordic_angle, out_phase;
    logic [W-1:0]  cordic_x_start, cordic_y_start, cordic_cosine, cordic_sine;
    logic          out_valid, out_last, busy, error_timeout;
    logic [W-1:0]  out_cos, out_sin;

    always #5 clock = ~clock;

    cordic_phase_sequencer #(
        .WIDTH(W), .ANGLE_WIDTH(AW), .COUNT_WIDTH(CW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .cfg_load(cfg_load), .cfg_phase_init(cfg_phase_init),
        .cfg_phase_step(cfg_phase_step), .cfg_count(cfg_count),
        .run(run), .abort(abort),
        .cordic_start(cordic_start), .cordic_angle(cordic_angle),
        .cordic_x_start(cordic_x_start), .cordic_y_start(cordic_y_start),
        .cordic_cosine(cordic_cosine), .cordic_sine(cordic_sine),
        .cordic_done(cordic_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cos(out_cos), .out_sin(out_sin), .out_phase(out_phase),
        .out_last(out_last), .busy(busy), .error_timeout(error_timeout)
    );

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int accepts = 0;
    int valids = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] fcos(input logic [AW-1:0] ang);
        return ang[AW-1:AW-W] ^ 16'h1234;
    endfunction

    function automatic logic [W-1:0] fsin(input logic [AW-1:0] ang);
        return ang[W-1:0];
    endfunction

    // Stub core: fixed latency, result is a fixed function of the angle.
    logic model_en;
    int   mcnt;
    logic [AW-1:0] mang;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mcnt <= 0;
            mang <= '0;
            cordic_done <= 1'b0;
            cordic_cosine <= '0;
            cordic_sine <= '0;
        end else begin
            cordic_done <= 1'b0;
            if (cordic_start) begin
                mcnt <= LAT;
                mang <= cordic_angle;
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1 && model_en) begin
                    cordic_done <= 1'b1;
                    cordic_cosine <= fcos(mang);
                    cordic_sine <= fsin(mang);
                end
            end
        end
    end

    typedef struct {
        logic [AW-1:0] phase;
        logic [W-1:0]  c;
        logic [W-1:0]  s;
        logic          last;
    } exp_t;
    exp_t sb[$];

    always @(negedge clock) begin
        if (!reset) begin
            if (cordic_start) starts++;
            if (out_valid) valids++;
            if (out_valid && out_ready) begin
                accepts++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: phase %0h with empty scoreboard", out_phase);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_phase", out_phase, e.phase);
                    check("out_cos", out_cos, e.c);
                    check("out_sin", out_sin, e.s);
                    check("out_last", out_last, e.last);
                end
            end
        end
    end

    typedef struct {
        int init;
        int step;
        int count;
        int ph[4];
    } vec_t;
    vec_t vecs[4];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_expected(input vec_t v);
        for (int i = 0; i < v.count; i++) begin
            exp_t e;
            e.phase = v.ph[i];
            e.c = fcos(e.phase);
            e.s = fsin(e.phase);
            e.last = (i == v.count - 1);
            sb.push_back(e);
        end
    endtask

    task automatic start_run(input vec_t v);
        cfg_phase_init = v.init;
        cfg_phase_step = v.step;
        cfg_count = CW'(v.count);
        cfg_load = 1'b1;
        run = 1'b1;
        tick();
        cfg_load = 1'b0;
        run = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        check(name, (busy == 1'b0 && sb.size() == 0), 1);
    endtask

    task automatic wait_accepts(input int target);
        int n = 0;
        while (accepts < target && n < 200) begin
            tick();
            n++;
        end
        check("wait_accepts", accepts >= target, 1);
    endtask

    initial begin
        int a0, s0, v0, n;
        vecs[0] = '{init: 0, step: 843314856, count: 4,
                    ph: '{0, 843314856, 1686629712, -843314858}};
        vecs[1] = '{init: 1686629712, step: 2, count: 2,
                    ph: '{1686629712, -1686629712, 0, 0}};
        vecs[2] = '{init: -1686629713, step: -1, count: 2,
                    ph: '{-1686629713, 1686629712, 0, 0}};
        vecs[3] = '{init: 100, step: 1000, count: 3, ph: '{100, 1100, 2100, 0}};

        reset = 1'b1;
        cfg_load = 0; run = 0; abort = 0; out_ready = 1;
        cfg_phase_init = '0; cfg_phase_step = '0; cfg_count = '0;
        model_en = 1'b1;
        tick();
        tick();
        check("rst_cordic_start", cordic_start, 0);
        check("rst_cordic_angle", cordic_angle, 0);
        check("rst_x_start", cordic_x_start, 9949);
        check("rst_y_start", cordic_y_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_cos", out_cos, 0);
        check("rst_out_phase", out_phase, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error_timeout, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            push_expected(vecs[i]);
            start_run(vecs[i]);
            check("busy_on_run", busy, 1);
            wait_done("sweep_done");
            check("busy_after", busy, 0);
        end

        // Backpressure on sample 2.
        push_expected(vecs[0]);
        a0 = accepts;
        start_run(vecs[0]);
        wait_accepts(a0 + 1);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check("bp_valid_rise", out_valid, 1);
        s0 = starts;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_valid_hold", out_valid, 1);
            check("bp_phase_hold", out_phase, sb[0].phase);
            check("bp_cos_hold", out_cos, sb[0].c);
            check("bp_sin_hold", out_sin, sb[0].s);
        end
        check("bp_no_start", starts, s0);
        check("bp_accepts", accepts, a0 + 1);
        out_ready = 1'b1;
        tick();
        tick();
        check("bp_one_accept", accepts, a0 + 2);
        wait_done("bp_done");

        // Abort during the first request's WAIT.
        v0 = valids;
        start_run(vecs[3]);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_drain_busy", busy, 1);
        n = 0;
        while (!cordic_done && n < 40) begin
            tick();
            n++;
        end
        check("abort_done_seen", cordic_done, 1);
        check("abort_busy_at_done", busy, 1);
        tick();
        check("abort_idle", busy, 0);
        check("abort_no_valid", valids, v0);
        check("abort_no_error", error_timeout, 0);
        push_expected(vecs[1]);
        start_run(vecs[1]);
        wait_done("post_abort_sweep");

        // Timeout with a silent core.
        model_en = 1'b0;
        v0 = valids;
        start_run(vecs[3]);
        check("to_start_now", cordic_start, 1);
        for (int j = 1; j <= 256; j++) begin
            tick();
            if (j == 255) begin
                check("to_err_before", error_timeout, 0);
                check("to_busy_before", busy, 1);
            end
        end
        check("to_err_set", error_timeout, 1);
        check("to_idle", busy, 0);
        check("to_no_valid", valids, v0);
        model_en = 1'b1;
        push_expected(vecs[3]);
        start_run(vecs[3]);
        check("to_err_cleared", error_timeout, 0);
        wait_done("post_to_sweep");

        // count == 0 produces nothing.
        s0 = starts;
        cfg_phase_init = 5; cfg_phase_step = 5; cfg_count = '0;
        cfg_load = 1'b1; run = 1'b1;
        tick();
        cfg_load = 1'b0; run = 1'b0;
        repeat (30) tick();
        check("cnt0_no_start", starts, s0);
        check("cnt0_idle", busy, 0);

        // Mid-sweep cfg_load is ignored; the latched config stays in force.
        push_expected(vecs[3]);
        a0 = accepts;
        start_run(vecs[3]);
        wait_accepts(a0 + 1);
        cfg_phase_init = 7; cfg_phase_step = 5; cfg_count = 16'd1;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        wait_done("cfg_protect_sweep");
        push_expected(vecs[3]);
        run = 1'b1;
        tick();
        run = 1'b0;
        wait_done("cfg_latched_rerun");

        // Reset mid-sweep.
        push_expected(vecs[0]);
        start_run(vecs[0]);
        repeat (8) tick();
        reset = 1'b1;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_angle", cordic_angle, 0);
        sb.delete();
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
